inner_fn_lat: RTL and testbench
===============================

Name: inner_fn_lat

Overview:
- Multi-cycle floating-point function unit, Nios-II custom-instruction style (start/done handshake, clk_en qualifier).
- Computes f(x) = 0.5*x + x^2 * cos((x - 128)/128) for one IEEE-754 single-precision operand.
- Cosine is evaluated by an iterative fixed-point CORDIC.
- Serves as the per-element inner stage of the cosine accelerator.

Parameters:
- CORDIC_ITERS, 16, number of CORDIC micro-rotations; total latency LATENCY = CORDIC_ITERS + 6.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- aclr  input  1  asynchronous active-high reset.
- clk_en  input  1  clock enable; state advances only on rising edges where clk_en=1.
- start  input  1  launches a computation on dataa.
- dataa  input  32  operand x, IEEE-754 single.
- result  output  32  f(x), IEEE-754 single.
- done  output  1  one-cycle pulse: result valid.

Behaviour:
- One clock (clock); aclr is asynchronous, active-high. While aclr=1: done=0, result=0x00000000, FSM in IDLE, all datapath registers cleared.
- An "enabled edge" is a rising clock edge with clk_en=1. When clk_en=0, all registers hold, including done and the cycle counter.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY: enabled edge with start=1. dataa is captured on this edge.
  - BUSY: counter runs; exits after LATENCY enabled edges counted from the start edge.
  - DONE: done=1 and result updated. Lasts exactly one enabled edge, then returns to IDLE.
- done rises on the LATENCY-th enabled edge after the start edge, i.e. after 22 enabled edges at the default.
- result holds its value until the next completion or reset.
- start is ignored in BUSY and DONE; it is sampled only in IDLE.
- Operand domain: 0.0 <= x <= 255.0. Outside it, the result value is unspecified but the handshake and latency are unchanged. Sign bit set is treated as out of range.
- Datapath steps:
  1. Unpack float to unsigned fixed Q8.16 (truncate bits below 2^-16; exponent < -16 gives 0).
  2. Angle a = x/128 - 1 in signed Q2.16, range [-1, +0.9922] rad; no quadrant reduction needed.
  3. CORDIC rotation mode, CORDIC_ITERS iterations, one per enabled edge. Initial X = K = 0.607253 (Q1.16), Y = 0, Z = a. Atan table arctan(2^-i) in Q2.16. Output cos in signed Q1.16.
  4. Compute x^2 (Q16.32) concurrently with the CORDIC.
  5. p = x^2 * cos (signed).
  6. s = p + x/2. s is non-negative over the domain.
  7. Normalise s to single precision with a leading-one detector; mantissa truncated (round toward zero). s = 0 gives +0.0 (0x00000000).
- Accuracy: |result - f(x)| <= 1e-4 * |f(x)| + 1e-3 over the whole domain.
- Reset mid-operation aborts the computation: the unit returns to IDLE and no done pulse is produced.
- start coincident with the DONE edge is ignored; a new start must be presented in IDLE.

Test Plan:
- Reset then release: done=0, result=0x00000000. Start with x=0x00000000 -> done pulse after exactly 22 enabled edges, result=0x00000000.
- Sweep x=25,50,75,100,125,150,175,200,225,250,255 (0x41c80000 ... 0x437f0000), one at a time, waiting for done. Each result must be within tolerance of 0x43deea9d, 0x4501b0c0, 0x45a219d4, 0x46194f03, 0x46750d13, 0x46adc721, 0x46dffe6e, 0x4704912a, 0x471013f6, 0x470de056, 0x470b667f. Examples: x=25 -> 445.83; x=255 -> 35686.50.
- Drop clk_en for 5 cycles mid-computation (x=100): done is delayed by exactly 5 cycles; result is still ~9811.75 (0x46194f03).
- Pulse start again while BUSY with a different dataa: the second start is ignored; result corresponds to the first operand; only one done pulse occurs.
- Assert aclr mid-computation: done never pulses, result=0. A fresh start with x=50 completes normally with result ~2075.05.
- done is high for exactly one enabled cycle; result holds after done until the next completion.

Source files
------------

// File: rtl/inner_fn_lat.sv
`default_nettype none
// ============================================================================
//  Module      : inner_fn_lat
//  Description : Multi-cycle single-precision function unit with a start/done
//                handshake and clock-enable qualifier. It computes
//                f(x) = 0.5*x + x^2 * cos((x - 128)/128). The cosine comes
//                from an iterative CORDIC that does one micro-rotation per
//                enabled edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module inner_fn_lat #(
  parameter int CORDIC_ITERS = 16
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  localparam int LATENCY = CORDIC_ITERS + 6;
  localparam int CW      = $clog2(LATENCY + 1);

  // Schedule of datapath steps, indexed by enabled edges after the start edge
  localparam logic [CW-1:0] C_UNPACK = CW'(1);
  localparam logic [CW-1:0] C_INIT   = CW'(2);
  localparam logic [CW-1:0] C_IT0    = CW'(3);
  localparam logic [CW-1:0] C_ITN    = CW'(CORDIC_ITERS + 2);
  localparam logic [CW-1:0] C_MUL    = CW'(CORDIC_ITERS + 3);
  localparam logic [CW-1:0] C_SUM    = CW'(CORDIC_ITERS + 4);
  localparam logic [CW-1:0] C_NORM   = CW'(CORDIC_ITERS + 5);
  localparam logic [CW-1:0] C_PACK   = CW'(LATENCY);

  // The CORDIC carries 4 guard bits below Q.16 (Q.20 internally) so that
  // truncation in the micro-rotations stays below the Q1.16 cosine LSB.
  // The gain constant is K = 0.607253 expressed in Q1.20.
  localparam logic signed [23:0] K_INIT = 24'sd636751;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [31:0]          xin_q;
  logic [23:0]          fx_q;      // x in unsigned Q8.16
  logic [47:0]          x2_q;      // x^2 in unsigned Q16.32
  logic signed [23:0]   cx_q, cy_q, cz_q;
  logic signed [34:0]   p_q;       // x^2*cos, in units of 2^-16
  logic signed [35:0]   s_q;       // p + x/2, in units of 2^-16
  logic [7:0]           exp_q;
  logic [22:0]          mant_q;
  logic                 zero_q;
  logic [31:0]          result_q;
  logic                 done_q;

  // arctan(2^-i) in Q2.20
  function automatic logic [23:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 24'd823550;
      1:       atan_lut = 24'd486170;
      2:       atan_lut = 24'd256879;
      3:       atan_lut = 24'd130396;
      4:       atan_lut = 24'd65451;
      5:       atan_lut = 24'd32757;
      6:       atan_lut = 24'd16383;
      7:       atan_lut = 24'd8192;
      8:       atan_lut = 24'd4096;
      default: atan_lut = (i <= 20) ? 24'(1 << (20 - i)) : 24'd0;
    endcase
  endfunction

  logic [7:0]  ex;
  logic [23:0] mant24;
  logic [23:0] fx_d;
  // Unpack the float to Q8.16. Bits below 2^-16 are truncated. A negative
  // operand is outside the domain and is flushed to zero.
  always_comb begin
    ex     = xin_q[30:23];
    mant24 = {1'b1, xin_q[22:0]};
    if (xin_q[31])
      fx_d = '0;
    else if (ex >= 8'd134)
      fx_d = mant24 << (ex - 8'd134);
    else
      fx_d = mant24 >> (8'd134 - ex);
  end

  logic signed [23:0] a_d;
  logic [47:0]        x2_d;
  // Compute the angle a = x/128 - 1 in Q.20 and the square x^2
  always_comb begin
    a_d  = $signed({3'b000, fx_q[23:3]}) - $signed(24'h100000);
    x2_d = {24'd0, fx_q} * {24'd0, fx_q};
  end

  logic [CW-1:0]      iter_idx;
  logic signed [23:0] xs, ys, at;
  logic signed [23:0] cx_d, cy_d, cz_d;
  // One CORDIC micro-rotation, steered by the sign of the residual angle
  always_comb begin
    iter_idx = cnt_q - C_IT0;
    xs       = cx_q >>> iter_idx;
    ys       = cy_q >>> iter_idx;
    at       = $signed(atan_lut(int'(iter_idx)));
    if (!cz_q[23]) begin
      cx_d = cx_q - ys;
      cy_d = cy_q + xs;
      cz_d = cz_q - at;
    end else begin
      cx_d = cx_q + ys;
      cy_d = cy_q - xs;
      cz_d = cz_q + at;
    end
  end

  logic signed [17:0] cos_d;
  logic signed [66:0] prod_d;
  logic signed [34:0] p_d;
  logic signed [35:0] s_d;
  // Round the cosine to Q1.16, multiply by x^2 and add x/2
  always_comb begin
    cos_d  = 18'((cx_q + 24'sd8) >>> 4);
    prod_d = $signed({19'd0, x2_q}) * $signed({{49{cos_d[17]}}, cos_d});
    p_d    = 35'(prod_d >>> 32);
    s_d    = $signed({p_q[34], p_q}) + $signed({13'd0, fx_q[23:1]});
  end

  logic [5:0]  lead_d;
  logic [35:0] norm_d;
  logic [7:0]  exp_d;
  logic [22:0] mant_d;
  logic        zero_d;
  // Leading-one detection and normalisation. A negative sum (only possible
  // outside the domain) is flushed to +0.
  always_comb begin
    lead_d = '0;
    for (int i = 0; i < 35; i++) begin
      if (s_q[i]) lead_d = 6'(i);
    end
    zero_d = s_q[35] | (s_q == '0);
    norm_d = $unsigned(s_q) << (6'd35 - lead_d);
    mant_d = 23'(norm_d >> 12);
    exp_d  = {2'b00, lead_d} + 8'd111;
  end

  // Control FSM and datapath registers. All state advances only on enabled edges.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      xin_q    <= '0;
      fx_q     <= '0;
      x2_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      cz_q     <= '0;
      p_q      <= '0;
      s_q      <= '0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            xin_q   <= dataa;
            cnt_q   <= C_UNPACK;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == C_UNPACK) fx_q <= fx_d;
          if (cnt_q == C_INIT) begin
            cx_q <= K_INIT;
            cy_q <= '0;
            cz_q <= a_d;
            x2_q <= x2_d;
          end
          if (cnt_q >= C_IT0 && cnt_q <= C_ITN) begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            cz_q <= cz_d;
          end
          if (cnt_q == C_MUL) p_q <= p_d;
          if (cnt_q == C_SUM) s_q <= s_d;
          if (cnt_q == C_NORM) begin
            exp_q  <= exp_d;
            mant_q <= mant_d;
            zero_q <= zero_d;
          end
          if (cnt_q == C_PACK) begin
            result_q <= zero_q ? 32'd0 : {1'b0, exp_q, mant_q};
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_inner_fn_lat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inner_fn_lat
//  Description : Directed self-checking bench for inner_fn_lat. It covers the
//                handshake, latency, clk_en stalls, ignored starts, abort by
//                reset and the value sweep across the operand domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inner_fn_lat;

  logic        clock = 1'b0;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  int n_checks;
  int n_pass;
  int lat;
  int pulses;

  // Operands x = 25, 50, ... 250, 255 and the reference f(x) values
  logic [31:0] xs [11] = '{32'h41c80000, 32'h42480000, 32'h42960000, 32'h42c80000,
                           32'h42fa0000, 32'h43160000, 32'h432f0000, 32'h43480000,
                           32'h43610000, 32'h437a0000, 32'h437f0000};
  logic [31:0] rs [11] = '{32'h43deea9d, 32'h4501b0c0, 32'h45a219d4, 32'h46194f03,
                           32'h46750d13, 32'h46adc721, 32'h46dffe6e, 32'h4704912a,
                           32'h471013f6, 32'h470de056, 32'h470b667f};
  int          xv [11] = '{25, 50, 75, 100, 125, 150, 175, 200, 225, 250, 255};

  inner_fn_lat #(.CORDIC_ITERS(16)) dut (
    .clock  (clock),
    .aclr   (aclr),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  always #5 clock = ~clock;

  function automatic real f2r(input logic [31:0] b);
    real m;
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    r = m * (2.0 ** e);
    return b[31] ? -r : r;
  endfunction

  // Exact compare, or float compare within 1e-4*|f| + 1e-3 when approx is set
  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp, input bit approx);
    bit  ok;
    real a;
    real e;
    real tol;
    n_checks++;
    if (approx) begin
      a   = f2r(act);
      e   = f2r(exp);
      tol = 1.0e-4 * ((e < 0.0) ? -e : e) + 1.0e-3;
      ok  = ((a - e) <= tol) && ((e - a) <= tol);
    end else begin
      ok = (act === exp);
    end
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one operation, return the number of enabled edges until done
  task automatic run_op(input logic [31:0] x, output int l);
    dataa = x;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      tick();
      l++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    aclr     = 1'b1;
    clk_en   = 1'b1;
    start    = 1'b0;
    dataa    = 32'd0;

    // Reset state
    repeat (3) tick();
    check("rst_done",   32'(done), 32'd0, 1'b0);
    check("rst_result", result,    32'd0, 1'b0);
    aclr = 1'b0;
    repeat (2) tick();
    check("idle_done",   32'(done), 32'd0, 1'b0);
    check("idle_result", result,    32'd0, 1'b0);

    // x = 0: exact zero result, latency and single-cycle done
    run_op(32'h00000000, lat);
    check("x0_lat",  32'(lat),  32'd22, 1'b0);
    check("x0_done", 32'(done), 32'd1,  1'b0);
    check("x0_res",  result,    32'd0,  1'b0);
    tick();
    check("x0_done_len", 32'(done), 32'd0, 1'b0);

    // Value sweep across the domain
    for (int i = 0; i < 11; i++) begin
      run_op(xs[i], lat);
      check($sformatf("x%0d_lat", xv[i]), 32'(lat), 32'd22, 1'b0);
      check($sformatf("x%0d_res", xv[i]), result,   rs[i],  1'b1);
      tick();
    end

    // clk_en dropped for 5 cycles mid-computation stretches latency by 5
    dataa = 32'h42c80000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    clk_en = 1'b0;
    repeat (5) tick();
    clk_en = 1'b1;
    lat = 10;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("stall_lat", 32'(lat), 32'd27,        1'b0);
    check("stall_res", result,   32'h46194f03, 1'b1);
    clk_en = 1'b0;
    repeat (3) tick();
    check("stall_done_hold", 32'(done), 32'd1, 1'b0);
    clk_en = 1'b1;
    tick();
    check("stall_done_drop", 32'(done), 32'd0, 1'b0);

    // A second start while BUSY and a start on the DONE edge are both ignored
    dataa = 32'h41c80000;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (5) begin
      tick();
      lat++;
    end
    dataa = 32'h43480000;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("busy_start_lat", 32'(lat), 32'd22,       1'b0);
    check("busy_start_res", result,   32'h43deea9d, 1'b1);
    pulses = (done === 1'b1) ? 1 : 0;
    dataa = 32'h42480000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_edge_start", 32'(done), 32'd0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("single_pulse", 32'(pulses), 32'd1,        1'b0);
    check("result_hold",  result,       32'h43deea9d, 1'b1);

    // Reset mid-computation aborts: no done, result cleared
    dataa = 32'h42960000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    aclr = 1'b1;
    #1;
    check("abort_result", result,    32'd0, 1'b0);
    check("abort_done",   32'(done), 32'd0, 1'b0);
    tick();
    aclr = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0, 1'b0);
    run_op(32'h42480000, lat);
    check("after_abort_lat", 32'(lat), 32'd22,       1'b0);
    check("after_abort_res", result,   32'h4501b0c0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
